audio_sequencer: RTL and testbench

Playback controller for the 256×8 wavetable ROM that feeds the `pdm` audio modulator. It sequences wavetable reads at a fixed sample rate using a 16-bit phase accumulator. It steps through a 16-entry note pattern once every N video frames, counted from `vsync` rising edges from `hvsync_generator`. Each fetched sample is scaled by a per-note decaying envelope, and the result drives the 16-bit `pdm_in`.

---
 rtl/audio_seq_pkg.sv | 32 +++
 rtl/audio_sequencer_if.sv | 22 ++
 rtl/audio_env.sv | 58 +++++
 rtl/audio_sequencer.sv | 124 ++++++++++++
 tb/tb_audio_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/audio_seq_pkg.sv
// Shared types and tables for the wavetable audio sequencer: FSM states,
// note increment table, the 16-step pattern and the envelope scaler.
package audio_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    FETCH,
    CAPTURE,
    OUTPUT
  } state_t;

  localparam logic [7:0] ENV_FULL = 8'hFF;

  // Phase increments per note; note 0 is a rest and never advances the phase.
  localparam logic [15:0] NOTE_INCR [16] = '{
    16'h0000, 16'h0100, 16'h0200, 16'h0180,
    16'h0240, 16'h0300, 16'h0360, 16'h0400,
    16'h0480, 16'h0510, 16'h05A0, 16'h0640,
    16'h06C0, 16'h0780, 16'h0840, 16'h0900
  };

  localparam logic [3:0] PATTERN [16] = '{
    4'd1, 4'd0, 4'd2, 4'd3, 4'd1, 4'd4, 4'd0, 4'd5,
    4'd6, 4'd7, 4'd8, 4'd0, 4'd9, 4'd10, 4'd11, 4'd12
  };

  function automatic logic [15:0] scale(input logic [7:0] data, input logic [7:0] env);
    return 16'(data) * 16'(env);
  endfunction

endpackage

// File: rtl/audio_sequencer_if.sv
// Wavetable ROM read port and scaled-sample stream between the sequencer
// (master) and its ROM / pdm consumer (slave).
interface audio_sequencer_if;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [15:0] sample;
  logic        sample_valid;

  modport master (
    output rom_addr,
    output sample,
    output sample_valid,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    input  sample,
    input  sample_valid,
    output rom_data
  );
endinterface

// File: rtl/audio_env.sv
// Frame-rate side of the sequencer: vsync edge detect, frame counter,
// pattern step index and the per-note decaying envelope.
module audio_env
  import audio_seq_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 8,
  parameter int ENV_DECAY       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       count_en,
  input  logic       vsync,
  output logic       frame_evt,
  output logic [3:0] step,
  output logic [7:0] env
);

  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);
  localparam logic [7:0] DECAY = 8'(ENV_DECAY);

  logic          vsync_d_reg;
  logic [CW-1:0] frame_cnt_reg;
  logic [3:0]    step_reg;
  logic [7:0]    env_reg;

  assign frame_evt = vsync & ~vsync_d_reg;
  assign step      = step_reg;
  assign env       = env_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_d_reg   <= 1'b0;
      frame_cnt_reg <= '0;
      step_reg      <= 4'd0;
      env_reg       <= ENV_FULL;
    end else begin
      vsync_d_reg <= vsync;
      // A stopped sequencer restarts from step 0 at full envelope level.
      if (clear) begin
        frame_cnt_reg <= '0;
        step_reg      <= 4'd0;
        env_reg       <= ENV_FULL;
      end else if (count_en && frame_evt) begin
        if (frame_cnt_reg == CNT_LAST) begin
          frame_cnt_reg <= '0;
          step_reg      <= step_reg + 4'd1;
          env_reg       <= ENV_FULL;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + CW'(1);
          env_reg       <= (env_reg >= DECAY) ? env_reg - DECAY : 8'd0;
        end
      end
    end
  end

endmodule

// File: rtl/audio_sequencer.sv
// Wavetable playback controller: prescaled sample ticks drive a phase
// accumulator into the ROM, and each sample is scaled by the note envelope.
module audio_sequencer
  import audio_seq_pkg::*;
#(
  parameter int SAMPLE_DIV      = 1024,
  parameter int FRAMES_PER_STEP = 8,
  parameter int ENV_DECAY       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      vsync,
  audio_sequencer_if.master         bus,
  output logic [3:0]                step,
  output logic                      playing
);

  localparam int PW = $clog2(SAMPLE_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_DIV - 1);

  state_t        state_reg;
  logic [PW-1:0] presc_reg;
  logic [15:0]   phase_reg;
  logic [7:0]    rom_addr_reg;
  logic [7:0]    data_reg;
  logic [15:0]   sample_reg;
  logic          sample_valid_reg;
  logic          playing_reg;

  logic [7:0]    env;
  logic [3:0]    note;
  logic [15:0]   incr;
  logic          rest;
  logic          env_clear;
  logic          env_count;
  logic          frame_evt_unused;

  assign note      = PATTERN[step];
  assign incr      = NOTE_INCR[note];
  assign rest      = (note == 4'd0);
  assign env_clear = ~enable;
  assign env_count = (state_reg != IDLE);

  audio_env #(
    .FRAMES_PER_STEP (FRAMES_PER_STEP),
    .ENV_DECAY       (ENV_DECAY)
  ) u_env (
    .clk       (clk),
    .reset     (reset),
    .clear     (env_clear),
    .count_en  (env_count),
    .vsync     (vsync),
    .frame_evt (frame_evt_unused),
    .step      (step),
    .env       (env)
  );

  assign bus.rom_addr     = rom_addr_reg;
  assign bus.sample       = sample_reg;
  assign bus.sample_valid = sample_valid_reg;
  assign playing          = playing_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      presc_reg        <= '0;
      phase_reg        <= 16'd0;
      rom_addr_reg     <= 8'd0;
      data_reg         <= 8'd0;
      sample_reg       <= 16'd0;
      sample_valid_reg <= 1'b0;
      playing_reg      <= 1'b0;
    end else begin
      sample_valid_reg <= 1'b0;
      if (!enable) begin
        // Abort wherever we are; an in-flight fetch never produces a pulse.
        state_reg   <= IDLE;
        playing_reg <= 1'b0;
        presc_reg   <= '0;
        phase_reg   <= 16'd0;
        sample_reg  <= 16'd0;
      end else begin
        // The prescaler free-runs through the fetch pipeline so ticks stay evenly spaced.
        if (state_reg != IDLE) begin
          presc_reg <= (presc_reg == PRESC_LAST) ? '0 : presc_reg + PW'(1);
        end
        case (state_reg)
          IDLE: begin
            state_reg   <= WAIT_TICK;
            playing_reg <= 1'b1;
            presc_reg   <= '0;
          end
          WAIT_TICK: begin
            if (presc_reg == PRESC_LAST) begin
              state_reg <= FETCH;
            end
          end
          FETCH: begin
            rom_addr_reg <= phase_reg[15:8];
            if (!rest) begin
              phase_reg <= phase_reg + incr;
            end
            state_reg <= CAPTURE;
          end
          CAPTURE: begin
            data_reg  <= bus.rom_data;
            state_reg <= OUTPUT;
          end
          OUTPUT: begin
            sample_reg       <= rest ? 16'd0 : scale(data_reg, env);
            sample_valid_reg <= 1'b1;
            state_reg        <= WAIT_TICK;
          end
          default: begin
            state_reg   <= IDLE;
            playing_reg <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_sequencer.sv
// Directed bench for audio_sequencer: two instances (fast step / long decay)
// share stimulus and are checked against hand-computed vectors.
module tb_audio_sequencer;
  import audio_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       vsync;
  logic [3:0] step_a, step_b;
  logic       playing_a, playing_b;

  audio_sequencer_if bus_a ();
  audio_sequencer_if bus_b ();

  // Identity-ramp wavetable, data valid in the cycle after the address register updates.
  assign bus_a.rom_data = bus_a.rom_addr;
  assign bus_b.rom_data = bus_b.rom_addr;

  audio_sequencer #(.SAMPLE_DIV(8), .FRAMES_PER_STEP(2), .ENV_DECAY(8)) dut_a (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .vsync   (vsync),
    .bus     (bus_a),
    .step    (step_a),
    .playing (playing_a)
  );

  audio_sequencer #(.SAMPLE_DIV(8), .FRAMES_PER_STEP(40), .ENV_DECAY(8)) dut_b (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .vsync   (vsync),
    .bus     (bus_b),
    .step    (step_b),
    .playing (playing_b)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic        vs_after;
    int          gap;
    logic [7:0]  addr_a;
    logic [7:0]  addr_b;
    logic [15:0] smp_a;
    logic [15:0] smp_b;
    logic [3:0]  step_a;
    logic [7:0]  env_a;
    logic [7:0]  env_b;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      vsync = 1'b0;
      n++;
    end while (!bus_a.sample_valid && n < 40);
  endtask

  task automatic pulse();
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int seen;

    vecs[0] = '{1'b0, 12, 8'h00, 8'h00, 16'h0000, 16'h0000, 4'd0, 8'd255, 8'd255};
    vecs[1] = '{1'b1,  8, 8'h01, 8'h01, 16'h00FF, 16'h00FF, 4'd0, 8'd255, 8'd255};
    vecs[2] = '{1'b1,  8, 8'h02, 8'h02, 16'h01EE, 16'h01EE, 4'd0, 8'd247, 8'd247};
    vecs[3] = '{1'b0,  8, 8'h03, 8'h03, 16'h0000, 16'h02CD, 4'd1, 8'd255, 8'd239};
    vecs[4] = '{1'b1,  8, 8'h03, 8'h04, 16'h0000, 16'h03BC, 4'd1, 8'd255, 8'd239};
    vecs[5] = '{1'b1,  8, 8'h03, 8'h05, 16'h0000, 16'h0483, 4'd1, 8'd247, 8'd231};
    vecs[6] = '{1'b0,  8, 8'h03, 8'h06, 16'h02FD, 16'h053A, 4'd2, 8'd255, 8'd223};
    vecs[7] = '{1'b0,  8, 8'h05, 8'h07, 16'h04FB, 16'h0619, 4'd2, 8'd255, 8'd223};

    // Reset with vsync toggling
    reset = 1'b1; enable = 1'b0; vsync = 1'b0;
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    check("rst_playing", 32'(playing_a), 32'd0);
    check("rst_step", 32'(step_a), 32'd0);
    check("rst_sample", 32'(bus_a.sample), 32'd0);
    check("rst_valid", 32'(bus_a.sample_valid), 32'd0);
    check("rst_rom_addr", 32'(bus_a.rom_addr), 32'd0);
    check("rst_env_a", 32'(dut_a.u_env.env), 32'd255);
    check("rst_env_b", 32'(dut_b.u_env.env), 32'd255);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_playing_a", 32'(playing_a), 32'd0);
    check("idle_playing_b", 32'(playing_b), 32'd0);

    // Waveform, step and envelope table
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_valid(n);
      $display("vec %0d: gap=%0d addr_a=%0h sample_a=%0h sample_b=%0h step_a=%0d",
               k, n, bus_a.rom_addr, bus_a.sample, bus_b.sample, step_a);
      check($sformatf("gap[%0d]", k), 32'(n), 32'(vecs[k].gap));
      check($sformatf("valid_b[%0d]", k), 32'(bus_b.sample_valid), 32'd1);
      check($sformatf("addr_a[%0d]", k), 32'(bus_a.rom_addr), 32'(vecs[k].addr_a));
      check($sformatf("addr_b[%0d]", k), 32'(bus_b.rom_addr), 32'(vecs[k].addr_b));
      check($sformatf("sample_a[%0d]", k), 32'(bus_a.sample), 32'(vecs[k].smp_a));
      check($sformatf("sample_b[%0d]", k), 32'(bus_b.sample), 32'(vecs[k].smp_b));
      check($sformatf("step_a[%0d]", k), 32'(step_a), 32'(vecs[k].step_a));
      check($sformatf("env_a[%0d]", k), 32'(dut_a.u_env.env), 32'(vecs[k].env_a));
      check($sformatf("env_b[%0d]", k), 32'(dut_b.u_env.env), 32'(vecs[k].env_b));
      check($sformatf("playing[%0d]", k), 32'(playing_a), 32'd1);
      if (vecs[k].vs_after) vsync = 1'b1;
    end

    // Envelope saturation (dut_b) and step wrap (dut_a): 28 more frame events
    repeat (27) pulse();
    $display("31 events: env_b=%0d step_a=%0d env_a=%0d", dut_b.u_env.env, step_a, dut_a.u_env.env);
    check("env_b_31", 32'(dut_b.u_env.env), 32'd7);
    check("step_a_31", 32'(step_a), 32'd15);
    check("env_a_31", 32'(dut_a.u_env.env), 32'd247);
    check("step_b_31", 32'(step_b), 32'd0);
    pulse();
    $display("32 events: env_b=%0d step_a=%0d env_a=%0d", dut_b.u_env.env, step_a, dut_a.u_env.env);
    check("env_b_sat", 32'(dut_b.u_env.env), 32'd0);
    check("step_wrap", 32'(step_a), 32'd0);
    check("env_a_reload", 32'(dut_a.u_env.env), 32'd255);
    wait_valid(n);
    $display("saturated sample: sample_b=%0h", bus_b.sample);
    check("sat_valid", 32'(bus_a.sample_valid), 32'd1);
    check("sat_sample_b", 32'(bus_b.sample), 32'd0);
    repeat (2) pulse();
    check("step_a_34", 32'(step_a), 32'd1);

    // Abort in CAPTURE
    wait_valid(n);
    repeat (6) @(negedge clk);
    check("abort_in_capture", 32'(dut_a.state_reg), 32'(CAPTURE));
    enable = 1'b0;
    @(negedge clk);
    $display("abort: playing=%0d valid=%0d step=%0d", playing_a, bus_a.sample_valid, step_a);
    check("abort_state", 32'(dut_a.state_reg), 32'(IDLE));
    check("abort_playing", 32'(playing_a), 32'd0);
    check("abort_valid", 32'(bus_a.sample_valid), 32'd0);
    check("abort_step", 32'(step_a), 32'd0);
    check("abort_sample", 32'(bus_a.sample), 32'd0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_a.sample_valid) seen++;
    end
    check("abort_no_pulse", 32'(seen), 32'd0);

    // Frame event coincident with OUTPUT
    enable = 1'b1;
    wait_valid(n);
    check("restart_gap", 32'(n), 32'd12);
    check("restart_addr", 32'(bus_a.rom_addr), 32'd0);
    repeat (7) @(negedge clk);
    check("sim_in_output", 32'(dut_a.state_reg), 32'(OUTPUT));
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    $display("simultaneous: sample_a=%0h env_a=%0d", bus_a.sample, dut_a.u_env.env);
    check("sim_valid", 32'(bus_a.sample_valid), 32'd1);
    check("sim_sample_a", 32'(bus_a.sample), 32'h00FF);
    check("sim_sample_b", 32'(bus_b.sample), 32'h00FF);
    check("sim_env_a", 32'(dut_a.u_env.env), 32'd247);
    wait_valid(n);
    check("sim_next_gap", 32'(n), 32'd8);
    check("sim_next_sample", 32'(bus_a.sample), 32'h01EE);

    // Asynchronous reset mid-run
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    $display("async reset: playing=%0d sample=%0h addr=%0h", playing_a, bus_a.sample, bus_a.rom_addr);
    check("areset_playing", 32'(playing_a), 32'd0);
    check("areset_sample", 32'(bus_a.sample), 32'd0);
    check("areset_addr", 32'(bus_a.rom_addr), 32'd0);
    check("areset_valid", 32'(bus_a.sample_valid), 32'd0);
    check("areset_env", 32'(dut_a.u_env.env), 32'd255);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_a.sample_valid) seen++;
    end
    check("areset_no_pulse", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
